// File: rtl/hazard_detect_unit_pkg.sv
// hazard_pkg: FSM state encoding, counter width and a saturating increment helper
package hazard_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;
    localparam int CNT_W = 3;
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction
endpackage

// File: rtl/hazard_detect_unit_cmp.sv
// hazard_cmp: load-use compare of the EX load destination against ID sources
module hazard_cmp
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             hazard
);
    assign hazard = ex_mem_read && ex_rt != '0 &&
                    (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: load-use stall and branch flush control; HAZARD_STATS_EN adds stall/flush counters
module hazard_detect_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             control_valid,
    output logic             if_id_flush,
    output logic             id_ex_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_count,
    output logic [15:0]      flush_count
`endif
);
    localparam logic [CNT_W-1:0] STALL_LD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hazard;
    logic             flush_now;
    logic             stall_now;
    hazard_cmp #(.REG_W(REG_W)) u_cmp (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .hazard      (hazard)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == FLUSH || (state == STALL && !branch_taken)) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= RUN;
        end else if (branch_taken) begin
            state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt   <= (FLUSH_CYCLES > 1) ? FLUSH_LD : '0;
        end else if (hazard) begin
            state <= (STALL_CYCLES > 1) ? STALL : RUN;
            cnt   <= (STALL_CYCLES > 1) ? STALL_LD : '0;
        end
    end
    always_comb begin
        flush_now     = state == FLUSH || branch_taken;
        stall_now     = !flush_now && (state == STALL || hazard);
        pc_write      = !reset && !stall_now;
        if_id_write   = !reset && !stall_now;
        control_valid = !reset && !stall_now && !flush_now;
        if_id_flush   = reset || flush_now;
        id_ex_flush   = reset || flush_now;
    end
`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            stall_count <= sat_inc(stall_count, !pc_write);
            flush_count <= sat_inc(flush_count, id_ex_flush);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: scoreboard bench for the hazard controller with 3-cycle stalls and flushes
module tb_hazard_detect_unit;
    localparam int SC = 3;
    localparam int FC = 3;
    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mr;
        logic [4:0] ert;
        logic       br;
    } stim_t;
    localparam stim_t IDLE  = '{rst: 1'b0, rs: 5'd1, rt: 5'd2, uses: 1'b1, mr: 1'b0, ert: 5'd0, br: 1'b0};
    localparam stim_t HAZ   = '{rst: 1'b0, rs: 5'd5, rt: 5'd2, uses: 1'b1, mr: 1'b1, ert: 5'd5, br: 1'b0};
    localparam stim_t BR    = '{rst: 1'b0, rs: 5'd1, rt: 5'd2, uses: 1'b1, mr: 1'b0, ert: 5'd0, br: 1'b1};
    localparam stim_t HAZBR = '{rst: 1'b0, rs: 5'd5, rt: 5'd2, uses: 1'b1, mr: 1'b1, ert: 5'd5, br: 1'b1};
    localparam stim_t RST   = '{rst: 1'b1, rs: 5'd5, rt: 5'd2, uses: 1'b1, mr: 1'b1, ert: 5'd5, br: 1'b0};
    // Expected {pc_write, if_id_write, control_valid, if_id_flush, id_ex_flush}
    localparam logic [4:0] V_RUN   = 5'b11100;
    localparam logic [4:0] V_STALL = 5'b00000;
    localparam logic [4:0] V_FLUSH = 5'b11011;
    localparam logic [4:0] V_RST   = 5'b00011;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;
    logic       pc_write, if_id_write, control_valid, if_id_flush, id_ex_flush;
    logic [4:0] obs;
    logic [4:0] sb[$];
    int         checks = 0;
    int         errors = 0;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count, flush_count;
`endif
    hazard_detect_unit #(.REG_W(5), .STALL_CYCLES(SC), .FLUSH_CYCLES(FC)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_read   (ex_mem_read),
        .ex_rt         (ex_rt),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .control_valid (control_valid),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count   (stall_count),
        .flush_count   (flush_count)
`endif
    );
    always #5 clk = ~clk;
    assign obs = {pc_write, if_id_write, control_valid, if_id_flush, id_ex_flush};
    task automatic drive(input stim_t s, input logic [4:0] e);
        @(negedge clk);
        reset        = s.rst;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_uses_rt   = s.uses;
        ex_mem_read  = s.mr;
        ex_rt        = s.ert;
        branch_taken = s.br;
        sb.push_back(e);
        #2;
    endtask
    task automatic test_reset();
        logic [4:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(i < 3 ? RST : IDLE, i < 3 ? V_RST : V_RUN);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL reset cyc %0d got %b exp %b", i, obs, e); end
        end
    endtask
    task automatic test_no_hazard();
        stim_t      st[4];
        logic [4:0] e;
        st[0] = '{rst: 1'b0, rs: 5'd3, rt: 5'd5, uses: 1'b0, mr: 1'b1, ert: 5'd5, br: 1'b0};
        st[1] = '{rst: 1'b0, rs: 5'd0, rt: 5'd0, uses: 1'b1, mr: 1'b1, ert: 5'd0, br: 1'b0};
        st[2] = '{rst: 1'b0, rs: 5'd5, rt: 5'd5, uses: 1'b1, mr: 1'b0, ert: 5'd5, br: 1'b0};
        st[3] = '{rst: 1'b0, rs: 5'd3, rt: 5'd5, uses: 1'b1, mr: 1'b1, ert: 5'd5, br: 1'b0};
        for (int i = 0; i < 3 + SC + 1; i++) begin
            if (i < 4) drive(st[i], i < 3 ? V_RUN : V_STALL);
            else drive(IDLE, i < 3 + SC ? V_STALL : V_RUN);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL no_hazard cyc %0d got %b exp %b", i, obs, e); end
        end
    endtask
    task automatic test_load_use();
        logic [4:0] e;
        for (int i = 0; i <= SC; i++) begin
            drive(i < SC ? HAZ : IDLE, i < SC ? V_STALL : V_RUN);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL load_use cyc %0d got %b exp %b", i, obs, e); end
        end
    endtask
    task automatic test_back_to_back();
        logic [4:0] e;
        for (int i = 0; i <= 2 * SC; i++) begin
            drive(i < 2 * SC ? HAZ : IDLE, i < 2 * SC ? V_STALL : V_RUN);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL back_to_back cyc %0d got %b exp %b", i, obs, e); end
        end
    endtask
    task automatic test_branch();
        logic [4:0] e;
        for (int i = 0; i <= FC; i++) begin
            drive(i < 2 ? BR : IDLE, i < FC ? V_FLUSH : V_RUN);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL branch cyc %0d got %b exp %b", i, obs, e); end
        end
    endtask
    task automatic test_branch_vs_hazard();
        logic [4:0] e;
        for (int i = 0; i <= FC; i++) begin
            drive(i == 0 ? HAZBR : IDLE, i < FC ? V_FLUSH : V_RUN);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL branch_vs_hazard cyc %0d got %b exp %b", i, obs, e); end
        end
    endtask
    task automatic test_branch_mid_stall();
        logic [4:0] e;
        for (int i = 0; i <= FC + 1; i++) begin
            drive(i == 0 ? HAZ : (i == 1 ? HAZBR : IDLE), i == 0 ? V_STALL : (i <= FC ? V_FLUSH : V_RUN));
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL branch_mid_stall cyc %0d got %b exp %b", i, obs, e); end
        end
    endtask
    task automatic test_reset_mid_stall();
        logic [4:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(i == 0 ? HAZ : (i == 1 ? RST : IDLE), i == 0 ? V_STALL : (i == 1 ? V_RST : V_RUN));
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL reset_mid_stall cyc %0d got %b exp %b", i, obs, e); end
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_stall_counts got %0d/%0d exp 0/0", stall_count, flush_count);
        end
`endif
    endtask
`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        logic [4:0] e;
        drive(RST, V_RST);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stats_reset got %b exp %b", obs, e); end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i <= SC; i++) begin
                drive(i < SC ? HAZ : IDLE, i < SC ? V_STALL : V_RUN);
                e = sb.pop_front();
                checks++;
                if (obs !== e) begin errors++; $display("FAIL stats_stall %0d cyc %0d got %b exp %b", k, i, obs, e); end
            end
        for (int i = 0; i <= FC; i++) begin
            drive(i == 0 ? BR : IDLE, i < FC ? V_FLUSH : V_RUN);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL stats_branch cyc %0d got %b exp %b", i, obs, e); end
        end
        checks++;
        if (stall_count !== 16'(2 * SC)) begin
            errors++;
            $display("FAIL stall_count got %0d exp %0d", stall_count, 2 * SC);
        end
        checks++;
        if (flush_count !== 16'(FC)) begin
            errors++;
            $display("FAIL flush_count got %0d exp %0d", flush_count, FC);
        end
    endtask
`endif
    initial begin
        test_reset();
        test_no_hazard();
        test_load_use();
        test_back_to_back();
        test_branch();
        test_branch_vs_hazard();
        test_branch_mid_stall();
        test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
